// File: rtl/on_chip_fsm_pio_arb_if.sv
// Requester-side write handshakes plus the PIO slave bus driven by the arbiter.
// The master modport is the requester/observer side; the slave modport is the arbiter.
interface on_chip_fsm_pio_arb_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic              chipselect;
    logic              write_n;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              busy;

    modport master (
        output req0, addr0, wdata0, req1, addr1, wdata1,
        input  ack0, ack1, chipselect, write_n, address, writedata, busy
    );

    modport slave (
        input  req0, addr0, wdata0, req1, addr1, wdata1,
        output ack0, ack1, chipselect, write_n, address, writedata, busy
    );
endinterface

// File: rtl/on_chip_fsm_pio_arb.sv
// Round-robin arbiter funnelling two write requesters onto one PIO slave; strobe 1 cycle after grant, ack 1 cycle later.
// Requests are level and held until ack; they are only sampled in IDLE, so a loser simply waits.
module on_chip_fsm_pio_arb #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 reset_n,
    on_chip_fsm_pio_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t            state, next_state;
    logic              ptr, next_ptr;
    logic              gnt, next_gnt;
    logic [ADDR_W-1:0] next_address;
    logic [DATA_W-1:0] next_writedata;
    logic              next_cs, next_write_n, next_ack0, next_ack1;
    logic              pick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            gnt            <= 1'b0;
            bus.address    <= '0;
            bus.writedata  <= '0;
            bus.chipselect <= 1'b0;
            bus.write_n    <= 1'b1;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= next_state;
            ptr            <= next_ptr;
            gnt            <= next_gnt;
            bus.address    <= next_address;
            bus.writedata  <= next_writedata;
            bus.chipselect <= next_cs;
            bus.write_n    <= next_write_n;
            bus.ack0       <= next_ack0;
            bus.ack1       <= next_ack1;
            bus.busy       <= (next_state != IDLE);
        end
    end

    always_comb begin
        next_state     = state;
        next_ptr       = ptr;
        next_gnt       = gnt;
        next_address   = bus.address;
        next_writedata = bus.writedata;
        next_cs        = 1'b0;
        next_write_n   = 1'b1;
        next_ack0      = 1'b0;
        next_ack1      = 1'b0;
        // Pointer only breaks ties; a lone requester wins outright.
        pick           = (bus.req0 && bus.req1) ? ptr : bus.req1;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    next_gnt       = pick;
                    next_ptr       = ~pick;
                    next_address   = pick ? bus.addr1 : bus.addr0;
                    next_writedata = pick ? bus.wdata1 : bus.wdata0;
                    next_cs        = 1'b1;
                    next_write_n   = 1'b0;
                    next_state     = WRITE;
                end
            end
            WRITE: begin
                next_ack0  = ~gnt;
                next_ack1  = gnt;
                next_state = ACK;
            end
            ACK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end
endmodule
